// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: icodes, condition ifuns,
// register IDs, flag bit positions and the E/M control bundle.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] ICMOVXX = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'ha;
  localparam logic [3:0] IPOPQ   = 4'hb;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hf;

  localparam int ZF_BIT = 2;
  localparam int SF_BIT = 1;
  localparam int OF_BIT = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic       valid;
    logic [3:0] icode;
    logic [3:0] dste;
    logic       cnd;
  } em_ctl_t;

  localparam em_ctl_t EM_BUBBLE = '{
    valid: 1'b0,
    icode: INOP,
    dste:  RNONE,
    cnd:   1'b0
  };

endpackage

// File: rtl/execute_cc_if.sv
// E-stage inputs, M-stage outputs and pipeline control
// for the execute condition-code block.
interface execute_cc_if #(
  parameter int W = 64
);
  logic         e_valid;
  logic [3:0]   e_icode;
  logic [3:0]   e_ifun;
  logic         e_set_cc;
  logic [W-1:0] alu_result;
  logic         alu_overflow;
  logic [3:0]   e_dstE;
  logic         cc_inhibit;
  logic         m_stall;
  logic         m_bubble;

  logic         e_cnd;
  logic [2:0]   cc;
  logic         m_valid;
  logic [3:0]   m_icode;
  logic [W-1:0] m_valE;
  logic [3:0]   m_dstE;
  logic         m_cnd;

  modport master (
    output e_valid, e_icode, e_ifun,
    output e_set_cc, alu_result,
    output alu_overflow, e_dstE,
    output cc_inhibit, m_stall, m_bubble,
    input  e_cnd, cc,
    input  m_valid, m_icode, m_valE,
    input  m_dstE, m_cnd
  );

  modport slave (
    input  e_valid, e_icode, e_ifun,
    input  e_set_cc, alu_result,
    input  alu_overflow, e_dstE,
    input  cc_inhibit, m_stall, m_bubble,
    output e_cnd, cc,
    output m_valid, m_icode, m_valE,
    output m_dstE, m_cnd
  );
endinterface

// File: rtl/execute_cc_cond_eval.sv
// Pure combinational jXX/cmovXX condition evaluation.
// Shared with the fetch-side branch predictor checker.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] flags,
  output logic       cnd
);

  logic zf, sf, of, lt;

  assign zf = flags[ZF_BIT];
  assign sf = flags[SF_BIT];
  assign of = flags[OF_BIT];
  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    unique case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc.sv
// Execute-stage condition codes, branch/cmov condition
// and E/M pipeline register for the pipelined Y86 core.
module execute_cc
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input logic         clk,
  input logic         rst,
  execute_cc_if.slave bus
);

  logic [2:0] cc_q;
  logic [2:0] cc_next;
  logic       cc_we;
  logic       raw_cnd;
  logic       is_cond;
  logic       cnd;
  logic [3:0] dste_adj;

  em_ctl_t      em_q;
  em_ctl_t      em_d;
  logic [W-1:0] vale_q;

  cond_eval u_cond (
    .ifun  (bus.e_ifun),
    .flags (cc_q),
    .cnd   (raw_cnd)
  );

  assign is_cond = (bus.e_icode == IJXX)
                 | (bus.e_icode == ICMOVXX);
  assign cnd     = is_cond ? raw_cnd : 1'b1;

  // a not-taken cmov must not write its destination
  assign dste_adj =
    (bus.e_icode == ICMOVXX && !cnd) ? RNONE : bus.e_dstE;

  assign cc_next[ZF_BIT] = (bus.alu_result == '0);
  assign cc_next[SF_BIT] = bus.alu_result[W-1];
  assign cc_next[OF_BIT] = bus.alu_overflow;

  assign cc_we = bus.e_valid & bus.e_set_cc
               & ~bus.cc_inhibit
               & ~bus.m_stall & ~bus.m_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else if (cc_we) begin
      cc_q <= cc_next;
    end
  end

  always_comb begin
    em_d       = em_q;
    em_d.valid = bus.e_valid;
    em_d.icode = bus.e_icode;
    em_d.dste  = dste_adj;
    em_d.cnd   = cnd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      em_q   <= EM_BUBBLE;
      vale_q <= '0;
    end else if (bus.m_bubble) begin
      em_q   <= EM_BUBBLE;
      vale_q <= '0;
    end else if (!bus.m_stall) begin
      em_q   <= em_d;
      vale_q <= bus.alu_result;
    end
  end

  assign bus.e_cnd   = cnd;
  assign bus.cc      = cc_q;
  assign bus.m_valid = em_q.valid;
  assign bus.m_icode = em_q.icode;
  assign bus.m_valE  = vale_q;
  assign bus.m_dstE  = em_q.dste;
  assign bus.m_cnd   = em_q.cnd;

endmodule
